// File: rtl/b8b10_pkg.sv
// rtl/b8b10_pkg.sv - shared 8b/10b comma constants and word-sync state enum
package b8b10_pkg;

  localparam logic [9:0] K28P5_RDN = 10'b0011111010;
  localparam logic [9:0] K28P5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } sync_state_e;

endpackage

// File: rtl/comma_detect.sv
// rtl/comma_detect.sv - flags a K28.5 code group of either running disparity
module comma_detect
  import b8b10_pkg::*;
(
  input  logic [9:0] code,
  output logic       is_comma
);

  assign is_comma = (code == K28P5_RDN) || (code == K28P5_RDP);

endmodule

// File: rtl/rx_sync_ctrl.sv
// rtl/rx_sync_ctrl.sv - 8b/10b receive word-sync acquisition and loss tracking
module rx_sync_ctrl
  import b8b10_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int LOSS_ERRS  = 4,
  parameter int GOOD_WIN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [9:0] encoded_val,
  input  logic       code_err,
  input  logic       err_clr,
  output logic       dec_enable,
  output logic       dec_rst,
  output logic       sync_ok,
  output logic       comma_seen,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] ACQ_N  = 4'(ACQ_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);
  localparam logic [3:0] GOOD_N = 4'(GOOD_WIN);

  sync_state_e state;
  logic [3:0]  comma_cnt;
  logic [3:0]  bad_cnt;
  logic [3:0]  good_run;
  logic        is_comma;
  logic        word_err;
  logic        word_comma;

  comma_detect u_comma_detect (
    .code     (encoded_val),
    .is_comma (is_comma)
  );

  // A comma carrying a code error counts only as an error.
  assign word_err   = valid_in & code_err;
  assign word_comma = valid_in & is_comma & ~code_err;

  assign sync_ok    = (state == SYNC);
  assign dec_rst    = rst | (state == LOS);
  assign dec_enable = valid_in & ~rst & (state != LOS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOS;
      comma_cnt  <= 4'd0;
      bad_cnt    <= 4'd0;
      good_run   <= 4'd0;
      err_cnt    <= 8'd0;
      comma_seen <= 1'b0;
    end else begin
      if (err_clr)
        err_cnt <= 8'd0;
      else if (word_err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      comma_seen <= word_comma;

      if (valid_in) begin
        case (state)
          LOS: begin
            if (word_comma) begin
              comma_cnt <= 4'd1;
              state     <= (ACQ_N == 4'd1) ? SYNC : ACQ;
            end
          end
          ACQ: begin
            if (code_err) begin
              state     <= LOS;
              comma_cnt <= 4'd0;
              bad_cnt   <= 4'd0;
              good_run  <= 4'd0;
            end else if (is_comma) begin
              comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt + 4'd1 == ACQ_N)
                state <= SYNC;
            end else begin
              comma_cnt <= 4'd0;
            end
          end
          SYNC: begin
            if (code_err) begin
              if (bad_cnt + 4'd1 == LOSS_N) begin
                state     <= LOS;
                comma_cnt <= 4'd0;
                bad_cnt   <= 4'd0;
                good_run  <= 4'd0;
              end else begin
                bad_cnt  <= bad_cnt + 4'd1;
                good_run <= 4'd0;
              end
            end else if (bad_cnt != 4'd0) begin
              // A full clean window forgives one outstanding error.
              if (good_run + 4'd1 == GOOD_N) begin
                bad_cnt  <= bad_cnt - 4'd1;
                good_run <= 4'd0;
              end else begin
                good_run <= good_run + 4'd1;
              end
            end else if (good_run != GOOD_N) begin
              good_run <= good_run + 4'd1;
            end
          end
          default: state <= LOS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb/tb_rx_sync_ctrl.sv - self-checking bench for rx_sync_ctrl
module tb_rx_sync_ctrl;

  localparam int ACQ_COMMAS = 3;
  localparam int LOSS_ERRS  = 4;
  localparam int GOOD_WIN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [9:0] encoded_val = 10'd0;
  logic       code_err = 1'b0;
  logic       err_clr = 1'b0;
  logic       dec_enable;
  logic       dec_rst;
  logic       sync_ok;
  logic       comma_seen;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: 0 = lost, 1 = acquiring, 2 = synchronised.
  int m_state  = 0;
  int m_commas = 0;
  int m_bad    = 0;
  int m_good   = 0;
  int m_err    = 0;
  int m_seen   = 0;

  typedef struct {
    logic       r;
    logic       v;
    logic [9:0] e;
    logic       ce;
    logic       cl;
    logic       x_sync;
    logic       x_seen;
    logic [7:0] x_err;
    logic       x_drst;
  } vec_t;

  vec_t tbl[21];

  rx_sync_ctrl #(
    .ACQ_COMMAS (ACQ_COMMAS),
    .LOSS_ERRS  (LOSS_ERRS),
    .GOOD_WIN   (GOOD_WIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .encoded_val (encoded_val),
    .code_err    (code_err),
    .err_clr     (err_clr),
    .dec_enable  (dec_enable),
    .dec_rst     (dec_rst),
    .sync_ok     (sync_ok),
    .comma_seen  (comma_seen),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, v, input logic [9:0] e, input logic ce, cl,
                              input logic xs, xc, input logic [7:0] xe, input logic xd);
    vec_t t;
    t.r = r; t.v = v; t.e = e; t.ce = ce; t.cl = cl;
    t.x_sync = xs; t.x_seen = xc; t.x_err = xe; t.x_drst = xd;
    return t;
  endfunction

  task automatic go_los();
    m_state = 0; m_commas = 0; m_bad = 0; m_good = 0;
  endtask

  task automatic model(input logic r, v, input logic [9:0] e, input logic ce, cl);
    bit comma;
    comma = (e == 10'h0FA) || (e == 10'h305);
    if (r) begin
      go_los();
      m_err = 0; m_seen = 0;
      return;
    end
    if (cl) m_err = 0;
    else if (v && ce && m_err < 255) m_err++;
    m_seen = (v && comma && !ce) ? 1 : 0;
    if (!v) return;
    case (m_state)
      0: if (comma && !ce) begin
        m_commas = 1;
        m_state = (ACQ_COMMAS == 1) ? 2 : 1;
      end
      1: if (ce) go_los();
         else if (comma) begin
           m_commas++;
           if (m_commas >= ACQ_COMMAS) m_state = 2;
         end else m_commas = 0;
      default: if (ce) begin
        m_bad++; m_good = 0;
        if (m_bad >= LOSS_ERRS) go_los();
      end else begin
        m_good++;
        if (m_bad > 0 && m_good >= GOOD_WIN) begin
          m_bad--; m_good = 0;
        end else if (m_good > GOOD_WIN) m_good = GOOD_WIN;
      end
    endcase
  endtask

  task automatic step(input logic r, v, input logic [9:0] e, input logic ce, cl);
    rst = r; valid_in = v; encoded_val = e; code_err = ce; err_clr = cl;
    #1;
    chk("dec_enable", int'(dec_enable), (v && !r && m_state != 0) ? 1 : 0);
    @(posedge clk);
    #1;
    model(r, v, e, ce, cl);
    chk("sync_ok", int'(sync_ok), (m_state == 2) ? 1 : 0);
    chk("comma_seen", int'(comma_seen), m_seen);
    chk("err_cnt", int'(err_cnt), m_err);
    chk("dec_rst", int'(dec_rst), (r || m_state == 0) ? 1 : 0);
  endtask

  initial begin
    //               r  v  enc     ce cl  sync seen err drst
    tbl[0]  = mk(1, 0, 10'h000, 0, 0, 0, 0, 8'd0, 1);
    tbl[1]  = mk(0, 1, 10'h0FA, 0, 0, 0, 1, 8'd0, 0);
    tbl[2]  = mk(0, 1, 10'h305, 0, 0, 0, 1, 8'd0, 0);
    tbl[3]  = mk(0, 1, 10'h0FA, 0, 0, 1, 1, 8'd0, 0);
    tbl[4]  = mk(0, 0, 10'h0FA, 0, 0, 1, 0, 8'd0, 0);
    tbl[5]  = mk(0, 1, 10'h000, 0, 0, 1, 0, 8'd0, 0);
    tbl[6]  = mk(1, 0, 10'h000, 0, 0, 0, 0, 8'd0, 1);
    tbl[7]  = mk(0, 1, 10'h0FA, 0, 0, 0, 1, 8'd0, 0);
    tbl[8]  = mk(0, 1, 10'h305, 0, 0, 0, 1, 8'd0, 0);
    tbl[9]  = mk(0, 1, 10'h2AA, 0, 0, 0, 0, 8'd0, 0);
    tbl[10] = mk(0, 1, 10'h0FA, 0, 0, 0, 1, 8'd0, 0);
    tbl[11] = mk(0, 1, 10'h0FA, 0, 0, 0, 1, 8'd0, 0);
    tbl[12] = mk(0, 1, 10'h305, 0, 0, 1, 1, 8'd0, 0);
    tbl[13] = mk(0, 1, 10'h000, 1, 0, 1, 0, 8'd1, 0);
    tbl[14] = mk(0, 1, 10'h000, 0, 0, 1, 0, 8'd1, 0);
    tbl[15] = mk(0, 1, 10'h000, 1, 0, 1, 0, 8'd2, 0);
    tbl[16] = mk(0, 1, 10'h000, 0, 0, 1, 0, 8'd2, 0);
    tbl[17] = mk(0, 1, 10'h000, 1, 0, 1, 0, 8'd3, 0);
    tbl[18] = mk(0, 1, 10'h000, 1, 0, 0, 0, 8'd4, 1);
    tbl[19] = mk(0, 1, 10'h0FA, 1, 0, 0, 0, 8'd5, 1);
    tbl[20] = mk(0, 1, 10'h000, 1, 1, 0, 0, 8'd0, 1);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].e, tbl[i].ce, tbl[i].cl);
      chk($sformatf("tbl%0d_sync", i), int'(sync_ok), int'(tbl[i].x_sync));
      chk($sformatf("tbl%0d_seen", i), int'(comma_seen), int'(tbl[i].x_seen));
      chk($sformatf("tbl%0d_err", i), int'(err_cnt), int'(tbl[i].x_err));
      chk($sformatf("tbl%0d_drst", i), int'(dec_rst), int'(tbl[i].x_drst));
    end

    // Errors spaced by full clean windows never accumulate to loss.
    step(1, 0, 10'h000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 10'h0FA, 0, 0);
    step(0, 1, 10'h000, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 10'h011, 0, 0);
    step(0, 1, 10'h000, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 10'h011, 0, 0);
    step(0, 1, 10'h000, 1, 0);
    step(0, 1, 10'h000, 1, 0);
    chk("win_sync_held", int'(sync_ok), 1);
    chk("win_err_cnt", int'(err_cnt), 4);

    // Acquisition aborted by an error.
    step(1, 0, 10'h000, 0, 0);
    step(0, 1, 10'h305, 0, 0);
    step(0, 1, 10'h0FA, 1, 0);
    chk("acq_err_drst", int'(dec_rst), 1);

    // Saturation, then clear winning over a simultaneous increment.
    for (int i = 0; i < 260; i++) step(0, 1, 10'h3FF, 1, 0);
    chk("err_sat", int'(err_cnt), 255);
    step(0, 1, 10'h3FF, 1, 1);
    chk("err_clr_win", int'(err_cnt), 0);

    // Idle cycles with a comma on the bus, then reset from SYNC.
    step(1, 0, 10'h000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 10'h0FA, 0, 0);
    step(0, 1, 10'h000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 10'h0FA, 0, 0);
      chk("idle_seen", int'(comma_seen), 0);
      chk("idle_sync", int'(sync_ok), 1);
    end
    step(1, 1, 10'h0FA, 1, 0);
    chk("rst_sync", int'(sync_ok), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_drst", int'(dec_rst), 1);
    step(0, 1, 10'h0FA, 0, 0);
    chk("post_rst_seen", int'(comma_seen), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       r, v, ce, cl;
      logic [9:0] e;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ce = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: e = 10'h0FA;
        1: e = 10'h305;
        default: e = 10'($urandom);
      endcase
      step(r, v, e, ce, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
